// File: rtl/mod_sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: legal configurations, FSM state
// encoding and the small-sigma functions for the 32- and 64-bit word widths.
package mod_sha2_pkg;

  localparam int unsigned SHA256_WORD_W = 32;
  localparam int unsigned SHA256_ROUNDS = 64;
  localparam int unsigned SHA512_WORD_W = 64;
  localparam int unsigned SHA512_ROUNDS = 80;

  localparam int unsigned WIN_DEPTH = 16;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned IDX_W     = 7;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_EXPAND = 1'b1
  } sched_state_e;

  function automatic bit legal_cfg(input int unsigned word_w, input int unsigned rounds);
    return ((word_w == SHA256_WORD_W) && (rounds == SHA256_ROUNDS)) ||
           ((word_w == SHA512_WORD_W) && (rounds == SHA512_ROUNDS));
  endfunction

  function automatic logic [31:0] sigma0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] sigma0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sigma1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

endpackage

// File: rtl/mod_sha2_sigma.sv
// Combinational small-sigma pair for the schedule recurrence, selected by word width.
module mod_sha2_sigma
  import mod_sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] s0_in_i,
  input  logic [WORD_W-1:0] s1_in_i,
  output logic [WORD_W-1:0] s0_o,
  output logic [WORD_W-1:0] s1_o
);

  if (WORD_W == SHA512_WORD_W) begin : g_w64
    assign s0_o = WORD_W'(sigma0_64(64'(s0_in_i)));
    assign s1_o = WORD_W'(sigma1_64(64'(s1_in_i)));
  end else begin : g_w32
    assign s0_o = WORD_W'(sigma0_32(32'(s0_in_i)));
    assign s1_o = WORD_W'(sigma1_32(32'(s1_in_i)));
  end

endmodule

// File: rtl/mod_msg_sched.sv
// SHA-2 message scheduler: loads 16 message words into a sliding window, then
// streams W[0..ROUNDS-1] with valid/ready backpressure.
module mod_msg_sched
  import mod_sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_word_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_word_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              out_last_o
);

  if (!legal_cfg(WORD_W, ROUNDS)) begin : g_bad_cfg
    $error("mod_msg_sched: illegal WORD_W/ROUNDS combination");
  end

  localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(WIN_DEPTH - 1);

  sched_state_e      state_q;
  logic [CNT_W-1:0]  load_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [WORD_W-1:0] win_q [WIN_DEPTH];

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;
  logic [WORD_W-1:0] win_new_d;
  logic              in_hs;
  logic              out_hs;

  mod_sha2_sigma #(
    .WORD_W (WORD_W)
  ) u_sigma (
    .s0_in_i (win_q[1]),
    .s1_in_i (win_q[14]),
    .s0_o    (s0),
    .s1_o    (s1)
  );

  // Next slot-15 value: W[t+16] from the window currently holding W[t..t+15].
  assign win_new_d = s1 + win_q[9] + s0 + win_q[0];
  assign in_hs     = in_valid_i && in_ready_q;
  assign out_hs    = out_valid_q && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_LOAD;
      load_cnt_q  <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_hs) begin
            win_q[load_cnt_q] <= in_word_i;
            load_cnt_q        <= load_cnt_q + 1'b1;
            if (load_cnt_q == LOAD_LAST) begin
              state_q     <= ST_EXPAND;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              idx_q       <= '0;
              out_last_q  <= 1'b0;
            end
          end
        end
        ST_EXPAND: begin
          if (out_hs) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
              win_q[i] <= win_q[i+1];
            end
            win_q[WIN_DEPTH-1] <= win_new_d;
            idx_q              <= idx_q + 1'b1;
            out_last_q         <= (idx_q == PRE_LAST_IDX);
            // Final word consumed: return to LOAD for the next block.
            if (out_last_q) begin
              state_q     <= ST_LOAD;
              load_cnt_q  <= '0;
              idx_q       <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_word_o  = win_q[0];
  assign out_idx_o   = idx_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_mod_msg_sched.sv
// Self-checking bench for mod_msg_sched: SHA-256 and SHA-512 schedule instances.
module tb_mod_msg_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv32, ir32, ov32, or32, ol32;
  logic [31:0] iw32, ow32;
  logic [6:0]  oi32;
  logic        iv64, ir64, ov64, or64, ol64;
  logic [63:0] iw64, ow64;
  logic [6:0]  oi64;

  mod_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv32), .in_ready_o(ir32), .in_word_i(iw32),
    .out_valid_o(ov32), .out_ready_i(or32), .out_word_o(ow32), .out_idx_o(oi32),
    .out_last_o(ol32));

  mod_msg_sched #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv64), .in_ready_o(ir64), .in_word_i(iw64),
    .out_valid_o(ov64), .out_ready_i(or64), .out_word_o(ow64), .out_idx_o(oi64),
    .out_last_o(ol64));

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] msg [16];
  logic [63:0] exp_w [80];
  logic [63:0] got_w [7][80];
  int          got_n [7];
  int          got_last [7];

  typedef struct {
    int          c;
    int          idx;   // -1: output count, -2: index carrying OUT_LAST
    logic [63:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  // Reference: textbook array form W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  task automatic build_model(input int sel);
    logic [31:0] s;
    logic [63:0] d;
    for (int t = 0; t < 16; t++) exp_w[t] = (sel == 0) ? {32'h0, msg[t][31:0]} : msg[t];
    for (int t = 16; t < 80; t++) begin
      if (sel == 0) begin
        s = (rr32(exp_w[t-2][31:0], 17) ^ rr32(exp_w[t-2][31:0], 19) ^ (exp_w[t-2][31:0] >> 10))
          + exp_w[t-7][31:0]
          + (rr32(exp_w[t-15][31:0], 7) ^ rr32(exp_w[t-15][31:0], 18) ^ (exp_w[t-15][31:0] >> 3))
          + exp_w[t-16][31:0];
        exp_w[t] = {32'h0, s};
      end else begin
        d = (rr64(exp_w[t-2], 19) ^ rr64(exp_w[t-2], 61) ^ (exp_w[t-2] >> 6)) + exp_w[t-7]
          + (rr64(exp_w[t-15], 1) ^ rr64(exp_w[t-15], 8) ^ (exp_w[t-15] >> 7)) + exp_w[t-16];
        exp_w[t] = d;
      end
    end
  endtask

  task automatic cmp_seq(input string name, input int c, input int sel);
    int errs = 0;
    build_model(sel);
    for (int t = 0; t < got_n[c] && t < 80; t++) if (got_w[c][t] !== exp_w[t]) errs++;
    chk(name, 64'(errs), 64'd0);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0]  = 64'h61626380;
    msg[15] = 64'h18;
  endtask

  task automatic set_one();
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0] = 64'h1;
  endtask

  task automatic sample(input int sel, output logic v, output logic [63:0] w,
                        output logic [6:0] i, output logic l, output logic ir);
    if (sel == 0) begin
      v = ov32; w = {32'h0, ow32}; i = oi32; l = ol32; ir = ir32;
    end else begin
      v = ov64; w = ow64; i = oi64; l = ol64; ir = ir64;
    end
  endtask

  task automatic set_rdy(input int sel, input logic r);
    if (sel == 0) or32 = r; else or64 = r;
  endtask

  // Feed msg[0..15]; keep=1 leaves IN_VALID high with a junk word afterwards.
  task automatic load(input int sel, input bit keep);
    logic v, l, ir;
    logic [63:0] w;
    logic [6:0] ix;
    int cyc;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (sel == 0) begin iv32 = 1'b1; iw32 = msg[k][31:0]; end
      else begin iv64 = 1'b1; iw64 = msg[k]; end
      cyc = 0;
      sample(sel, v, w, ix, l, ir);
      while (!ir && cyc < 200) begin
        @(negedge clk);
        cyc++;
        sample(sel, v, w, ix, l, ir);
      end
      if (!ir) begin
        chk("load_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk);
    end
    #1;
    sample(sel, v, w, ix, l, ir);
    chk("lat_out_valid", 64'(v), 64'd1);
    chk("lat_in_ready", 64'(ir), 64'd0);
    chk("lat_w0", w, (sel == 0) ? {32'h0, msg[0][31:0]} : msg[0]);
    chk("lat_idx0", 64'(ix), 64'd0);
    if (sel == 0) begin iv32 = keep; iw32 = 32'hDEADBEEF; end
    else begin iv64 = keep; iw64 = 64'hDEADBEEFCAFEF00D; end
  endtask

  // Drain one block into got_w[c]; returns 1 ns after the final handshake edge.
  task automatic collect(input int c, input int sel, input bit bp, input bit chk_ir);
    logic v, l, ir, r;
    logic [63:0] w, hw;
    logic [6:0] ix, hi;
    bit stalled = 0, done = 0;
    int n = 0, cyc = 0, nlast = 0, stall_errs = 0, stalls = 0, idx_errs = 0, ir_errs = 0;
    got_last[c] = 999;
    hw = '0;
    hi = '0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      set_rdy(sel, r);
      sample(sel, v, w, ix, l, ir);
      if (stalled) begin
        stalls++;
        if (!v || w !== hw || ix !== hi) stall_errs++;
      end
      if (chk_ir && v && ir) ir_errs++;
      if (v && r) begin
        if (n < 80) got_w[c][n] = w;
        if (32'(ix) != n) idx_errs++;
        if (l) begin
          nlast++;
          got_last[c] = int'(ix);
          done = 1;
        end
        n++;
      end
      stalled = v && !r;
      hw = w;
      hi = ix;
    end
    if (!done) chk("collect_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    set_rdy(sel, 1'b0);
    got_n[c] = n;
    chk("idx_order", 64'(idx_errs), 64'd0);
    if (bp && stalls > 0) chk("stall_stable", 64'(stall_errs), 64'd0);
    if (chk_ir) chk("no_accept_in_expand", 64'(ir_errs), 64'd0);
  endtask

  initial begin
    logic v, l, ir;
    logic [63:0] w;
    logic [6:0] ix;
    int cyc, errs;

    vecs[0]  = '{0, 0,  64'h61626380, "abc_w0"};
    vecs[1]  = '{0, 15, 64'h00000018, "abc_w15"};
    vecs[2]  = '{0, 16, 64'h61626380, "abc_w16"};
    vecs[3]  = '{0, 17, 64'h000F0000, "abc_w17"};
    vecs[4]  = '{0, -1, 64'd64,       "abc_count"};
    vecs[5]  = '{0, -2, 64'd63,       "abc_last_idx"};
    vecs[6]  = '{1, 16, 64'h1,        "one32_w16"};
    vecs[7]  = '{1, 17, 64'h0,        "one32_w17"};
    vecs[8]  = '{1, 18, 64'h0000A000, "one32_w18"};
    vecs[9]  = '{2, 16, 64'h1,        "one64_w16"};
    vecs[10] = '{2, 18, 64'h0000200000000008, "one64_w18"};
    vecs[11] = '{2, -1, 64'd80,       "one64_count"};
    vecs[12] = '{2, -2, 64'd79,       "one64_last_idx"};
    vecs[13] = '{3, -1, 64'd64,       "bp_count"};
    vecs[14] = '{4, -1, 64'd64,       "post_rst_count"};
    vecs[15] = '{5, -2, 64'd63,       "b2b1_last_idx"};
    vecs[16] = '{6, -1, 64'd64,       "b2b2_count"};

    iv32 = 0; iw32 = '0; or32 = 0;
    iv64 = 0; iw64 = '0; or64 = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_ir32", 64'(ir32), 64'd1);
    chk("rst_ov32", 64'(ov32), 64'd0);
    chk("rst_ow32", 64'(ow32), 64'd0);
    chk("rst_oi32", 64'(oi32), 64'd0);
    chk("rst_ol32", 64'(ol32), 64'd0);
    chk("rst_ir64", 64'(ir64), 64'd1);
    chk("rst_ov64", 64'(ov64), 64'd0);
    chk("rst_ow64", ow64, 64'd0);

    set_abc(); load(0, 0); collect(0, 0, 0, 0); cmp_seq("abc_seq", 0, 0);
    set_one(); load(0, 0); collect(1, 0, 0, 0); cmp_seq("one32_seq", 1, 0);
    set_one(); load(1, 0); collect(2, 1, 0, 0); cmp_seq("one64_seq", 2, 1);
    set_abc(); load(0, 0); collect(3, 0, 1, 0); cmp_seq("bp_seq", 3, 0);

    // Reset while W[30] is being presented.
    set_abc(); load(0, 0);
    cyc = 0;
    do begin
      @(negedge clk);
      or32 = 1'b1;
      cyc++;
    end while (!(ov32 && oi32 == 7'd30) && cyc < 200);
    chk("reach_idx30", 64'(oi32), 64'd30);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midrst_ov", 64'(ov32), 64'd0);
    chk("midrst_ir", 64'(ir32), 64'd1);
    chk("midrst_idx", 64'(oi32), 64'd0);
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (ov32) errs++;
    end
    chk("midrst_no_output", 64'(errs), 64'd0);
    or32 = 1'b0;
    set_abc(); load(0, 0); collect(4, 0, 0, 0); cmp_seq("post_rst_seq", 4, 0);

    // IN_VALID held high through EXPAND, blocks back to back.
    set_abc(); load(0, 1); collect(5, 0, 0, 1);
    sample(0, v, w, ix, l, ir);
    chk("b2b_inready_after_last", 64'(ir), 64'd1);
    chk("b2b_ov_after_last", 64'(v), 64'd0);
    load(0, 1); collect(6, 0, 0, 1);
    iv32 = 1'b0;
    cmp_seq("b2b1_seq", 5, 0);
    cmp_seq("b2b2_seq", 6, 0);

    for (int k = 0; k < NV; k++) begin
      case (vecs[k].idx)
        -1:      chk(vecs[k].name, 64'(got_n[vecs[k].c]), vecs[k].exp);
        -2:      chk(vecs[k].name, 64'(got_last[vecs[k].c]), vecs[k].exp);
        default: chk(vecs[k].name, got_w[vecs[k].c][vecs[k].idx], vecs[k].exp);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
